vga_shadow_loader: RTL and testbench



---
 rtl/vga_shadow_loader.sv | 157 +++++++++++++++
 tb/tb_vga_shadow_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_shadow_loader.sv
// Walks shadow-register addresses FIRST_ADDR..LAST_ADDR once per VSync falling edge,
// reading each value over req/ack and presenting it to the renderer as a one-cycle beat.
module vga_shadow_loader #(
  parameter int FIRST_ADDR  = 1,
  parameter int LAST_ADDR   = 12,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSync,
  output logic       rd_req,
  output logic [3:0] rd_addr,
  input  logic       rd_ack,
  input  logic [7:0] rd_data,
  output logic [3:0] MemAddrOut,
  output logic [7:0] MemDataOut,
  output logic       CS_DATA,
  input  logic       clr_err,
  output logic       busy,
  output logic       frame_done,
  output logic       err_timeout,
  output logic       err_abort,
  output logic [2:0] dbg_state
);

  // Handshake: rd_req/rd_addr stay stable until rd_ack is sampled high on a posedge;
  // rd_data is taken in that same cycle and rd_req drops on the following one.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_PRESENT = 3'd2,
    S_SKIP    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
  localparam logic [3:0]    FIRST = 4'(FIRST_ADDR);
  localparam logic [3:0]    LAST  = 4'(LAST_ADDR);
  localparam logic [TW-1:0] TMAX  = TW'(ACK_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          vs_q;
  logic          rd_req_q, rd_req_d;
  logic [3:0]    rd_addr_q, rd_addr_d;
  logic [3:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_data_q, mem_data_d;
  logic          cs_q, cs_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;
  logic          err_to_q, err_to_d;
  logic          err_ab_q, err_ab_d;
  logic          set_to, set_ab;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    tcnt_d     = tcnt_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    set_to     = 1'b0;
    set_ab     = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = FIRST;
        tcnt_d = '0;
        if (vs_q && !VSync) state_d = S_REQ;
      end
      S_REQ: begin
        if (VSync) begin
          state_d = S_IDLE;
          tcnt_d  = '0;
          set_ab  = 1'b1;
        end else if (rd_ack) begin
          state_d    = S_PRESENT;
          tcnt_d     = '0;
          mem_addr_d = addr_q;
          mem_data_d = rd_data;
        end else if (tcnt_q == TMAX) begin
          state_d = S_SKIP;
          tcnt_d  = '0;
          set_to  = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      // A skipped address advances exactly like a presented one, just without the strobe.
      S_PRESENT, S_SKIP: begin
        if (VSync) begin
          state_d = S_IDLE;
          set_ab  = 1'b1;
        end else if (addr_q == LAST) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 4'd1;
          state_d = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_req_d  = (state_d == S_REQ);
    rd_addr_d = (state_d == S_REQ) ? addr_d : rd_addr_q;
    cs_d      = (state_d == S_PRESENT);
    busy_d    = (state_d == S_REQ) || (state_d == S_PRESENT) || (state_d == S_SKIP);
    fd_d      = (state_d == S_DONE);
    err_to_d  = (err_to_q && !clr_err) || set_to;
    err_ab_d  = (err_ab_q && !clr_err) || set_ab;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      addr_q     <= FIRST;
      tcnt_q     <= '0;
      vs_q       <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= 4'd0;
      mem_addr_q <= 4'd0;
      mem_data_q <= 8'd0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
      fd_q       <= 1'b0;
      err_to_q   <= 1'b0;
      err_ab_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      tcnt_q     <= tcnt_d;
      vs_q       <= VSync;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      cs_q       <= cs_d;
      busy_q     <= busy_d;
      fd_q       <= fd_d;
      err_to_q   <= err_to_d;
      err_ab_q   <= err_ab_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign MemAddrOut  = mem_addr_q;
  assign MemDataOut  = mem_data_q;
  assign CS_DATA     = cs_q;
  assign busy        = busy_q;
  assign frame_done  = fd_q;
  assign err_timeout = err_to_q;
  assign err_abort   = err_ab_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_vga_shadow_loader.sv
// Bench for vga_shadow_loader: behavioural shadow bank, beat scoreboard, directed walks.
module tb_vga_shadow_loader;

  logic       CLK = 1'b0;
  logic       RESET, VSync, clr_err;
  logic       rd_req, rd_ack;
  logic [3:0] rd_addr, MemAddrOut;
  logic [7:0] rd_data, MemDataOut;
  logic       CS_DATA, busy, frame_done, err_timeout, err_abort;
  logic [2:0] dbg_state;

  vga_shadow_loader #(.FIRST_ADDR(1), .LAST_ADDR(12), .ACK_TIMEOUT(8)) dut (
    .CLK(CLK), .RESET(RESET), .VSync(VSync),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .MemAddrOut(MemAddrOut), .MemDataOut(MemDataOut), .CS_DATA(CS_DATA),
    .clr_err(clr_err), .busy(busy), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_abort(err_abort), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  logic [11:0] exp_q[$];
  logic [11:0] mon_e;
  logic [7:0]  data_tab[16];
  int          wait_cfg[16];
  int          req_cycles[16];
  int          fd_cnt, req_total, req_cnt, last_beat;
  bit          gap_chk, have_prev;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- shadow bank model ----------------
  initial begin
    rd_ack  = 1'b0;
    rd_data = 8'h00;
    req_cnt = 0;
  end

  always @(negedge CLK) begin
    if (rd_req) begin
      rd_ack  = (req_cnt == wait_cfg[rd_addr]);
      rd_data = rd_ack ? data_tab[rd_addr] : 8'h00;
      req_cnt++;
    end else begin
      rd_ack  = 1'b0;
      rd_data = 8'h00;
      req_cnt = 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    if (CS_DATA) begin
      if (exp_q.size() == 0) begin
        check("beat_unexpected", {20'd0, MemAddrOut, MemDataOut}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", {20'd0, MemAddrOut, MemDataOut}, {20'd0, mon_e});
        if (gap_chk && have_prev) check("beat_gap", cyc - last_beat, 2);
        have_prev = 1'b1;
        last_beat = cyc;
      end
    end
    if (frame_done) fd_cnt++;
    if (rd_req) begin
      req_cycles[rd_addr]++;
      req_total++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic clear_stats();
    fd_cnt    = 0;
    req_total = 0;
    have_prev = 1'b0;
    for (int i = 0; i < 16; i++) req_cycles[i] = 0;
  endtask

  task automatic push_range(int lo, int hi, int skip);
    for (int a = lo; a <= hi; a++)
      if (a != skip) exp_q.push_back({4'(a), data_tab[a]});
  endtask

  task automatic fall_vsync();
    VSync = 1'b1;
    tick(2);
    VSync = 1'b0;
  endtask

  task automatic wait_fd(string name, int budget);
    int n = 0;
    while (fd_cnt == 0 && n < budget) begin
      tick(1);
      n++;
    end
    check(name, fd_cnt, 1);
  endtask

  function automatic logic [31:0] out_vec();
    return {9'd0, rd_req, rd_addr, MemAddrOut, MemDataOut, CS_DATA, busy,
            frame_done, err_timeout, err_abort};
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int t0, t1, n;
    RESET   = 1'b1;
    VSync   = 1'b0;
    clr_err = 1'b0;
    gap_chk = 1'b0;
    for (int a = 0; a < 16; a++) begin
      data_tab[a] = 8'(8'h11 * a);
      wait_cfg[a] = 0;
    end
    clear_stats();
    tick(3);
    check("reset_outputs", out_vec(), 0);

    // VSync low through reset release must not start a walk
    RESET = 1'b0;
    tick(10);
    check("no_req_vsync_low", req_total, 0);
    check("idle_busy", busy, 0);

    // Walk with immediate acks
    VSync = 1'b1;
    tick(2);
    clear_stats();
    push_range(1, 12, 0);
    gap_chk = 1'b1;
    VSync   = 1'b0;
    n = 0;
    while (!rd_req && n < 10) begin
      tick(1);
      n++;
    end
    t0 = cyc;
    check("first_req_seen", rd_req, 1);
    check("first_req_addr", rd_addr, 1);
    n = 0;
    while (!frame_done && n < 60) begin
      tick(1);
      n++;
    end
    t1 = cyc;
    check("fd_seen", frame_done, 1);
    check("fd_latency", t1 - t0, 24);
    check("busy_at_fd", busy, 0);
    tick(1);
    check("fd_one_cycle", frame_done, 0);
    check("busy_after", busy, 0);
    check("walk1_beats_left", exp_q.size(), 0);
    gap_chk = 1'b0;

    // Address 5 acked after 3 wait cycles
    wait_cfg[5] = 3;
    data_tab[5] = 8'h37;
    clear_stats();
    push_range(1, 12, 0);
    fall_vsync();
    wait_fd("walk2_fd", 80);
    tick(1);
    check("addr5_req_cycles", req_cycles[5], 4);
    check("addr4_req_cycles", req_cycles[4], 1);
    check("walk2_beats_left", exp_q.size(), 0);
    wait_cfg[5] = 0;

    // Address 7 never acked
    wait_cfg[7] = 255;
    clear_stats();
    push_range(1, 12, 7);
    fall_vsync();
    wait_fd("walk3_fd", 100);
    tick(1);
    check("addr7_req_cycles", req_cycles[7], 8);
    check("addr8_req_cycles", req_cycles[8], 1);
    check("err_timeout_set", err_timeout, 1);
    check("err_abort_clear", err_abort, 0);
    check("walk3_beats_left", exp_q.size(), 0);
    wait_cfg[7] = 0;

    // Abort while waiting on address 4
    wait_cfg[4] = 255;
    clear_stats();
    push_range(1, 3, 0);
    fall_vsync();
    n = 0;
    while (!(rd_req && rd_addr == 4'd4) && n < 40) begin
      tick(1);
      n++;
    end
    check("addr4_req_seen", rd_req && rd_addr == 4'd4, 1);
    VSync = 1'b1;
    tick(1);
    check("abort_rd_req", rd_req, 0);
    check("abort_busy", busy, 0);
    check("abort_cs", CS_DATA, 0);
    check("abort_flag", err_abort, 1);
    tick(10);
    check("abort_no_fd", fd_cnt, 0);
    check("abort_beats_left", exp_q.size(), 0);
    check("timeout_sticky", err_timeout, 1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("clr_err_flags", {err_timeout, err_abort}, 0);

    // Restart after abort begins at address 1
    wait_cfg[4] = 0;
    clear_stats();
    push_range(1, 12, 0);
    VSync = 1'b0;
    wait_fd("restart_fd", 80);
    tick(1);
    check("restart_beats_left", exp_q.size(), 0);
    check("restart_addr1_req", req_cycles[1], 1);

    // Reset during PRESENT of address 9
    clear_stats();
    push_range(1, 9, 0);
    fall_vsync();
    n = 0;
    while (!(CS_DATA && MemAddrOut == 4'd9) && n < 60) begin
      tick(1);
      n++;
    end
    check("addr9_beat_seen", CS_DATA && MemAddrOut == 4'd9, 1);
    RESET = 1'b1;
    tick(1);
    check("reset_mid_walk", out_vec(), 0);
    RESET = 1'b0;
    tick(5);
    check("post_reset_idle", {rd_req, busy}, 0);
    check("post_reset_no_fd", fd_cnt, 0);
    check("reset_beats_left", exp_q.size(), 0);
    clear_stats();
    push_range(1, 12, 0);
    fall_vsync();
    wait_fd("post_reset_fd", 80);
    tick(1);
    check("post_reset_beats_left", exp_q.size(), 0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
